// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and types for the byte FIFO
//
// Purpose : word/pointer/count widths and the matching typedefs used by
//           fifo_if, fifo_ram_dp and fifo.
// Ports   : none (package).

package fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 5;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  // One extra bit so that a completely full FIFO (DEPTH words) is representable.
  typedef logic [ADDR_WIDTH:0]   cnt_t;

endpackage : fifo_pkg

// File: rtl/fifo_if.sv
// rtl/fifo_if.sv - producer/consumer handshake bundle for the byte FIFO
//
// Purpose : groups the push/pop/flush controls and the status/data outputs.
// Signals : CLEAR_N   synchronous active-low flush
//           READ      pop request
//           WRITE     push request
//           DATA_IN   word to push
//           DATA_OUT  current head word (show-ahead, 0 when empty)
//           F_FULL_N  0 when FIFO holds DEPTH words
//           F_EMPTY_N 0 when FIFO holds 0 words
//           USE_DW    word count modulo DEPTH
// Modports: master = producer/consumer side, slave = FIFO side.

interface fifo_if;
  import fifo_pkg::*;

  logic  CLEAR_N;
  logic  READ;
  logic  WRITE;
  data_t DATA_IN;
  data_t DATA_OUT;
  logic  F_FULL_N;
  logic  F_EMPTY_N;
  ptr_t  USE_DW;

  modport master (
    output CLEAR_N, READ, WRITE, DATA_IN,
    input  DATA_OUT, F_FULL_N, F_EMPTY_N, USE_DW
  );

  modport slave (
    input  CLEAR_N, READ, WRITE, DATA_IN,
    output DATA_OUT, F_FULL_N, F_EMPTY_N, USE_DW
  );

endinterface : fifo_if

// File: rtl/fifo_ram_dp.sv
// rtl/fifo_ram_dp.sv - DEPTH x DATA_WIDTH register array, sync write / async read
//
// Purpose : storage for the FIFO; contents are never reset.
// Ports   : clk   write clock (rising edge)
//           we    write enable
//           waddr write address
//           wdata write data
//           raddr read address
//           rdata combinational read data at raddr

module fifo_ram_dp
  import fifo_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  ptr_t  waddr,
  input  data_t wdata,
  input  ptr_t  raddr,
  output data_t rdata
);

  data_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read gives the FIFO its zero-latency show-ahead head word.
  assign rdata = mem[raddr];

endmodule : fifo_ram_dp

// File: rtl/fifo.sv
// rtl/fifo.sv - 32-deep single-clock byte FIFO with first-word-fall-through output
//
// Purpose : pointers, fill count, flags and head-word gating around fifo_ram_dp.
// Ports   : CLOCK  single clock, all state updates on rising edge
//           RESET  synchronous active-high reset
//           bus    fifo_if.slave (CLEAR_N, READ, WRITE, DATA_IN in;
//                  DATA_OUT, F_FULL_N, F_EMPTY_N, USE_DW out)

module fifo
  import fifo_pkg::*;
(
  input  logic  CLOCK,
  input  logic  RESET,
  fifo_if.slave bus
);

  ptr_t  wr_ptr;
  ptr_t  rd_ptr;
  cnt_t  count;
  data_t head;

  logic empty_n;
  logic full_n;
  logic flush;
  logic we;
  logic re;

  assign empty_n = (count != '0);
  assign full_n  = (count != cnt_t'(DEPTH));
  assign flush   = RESET | ~bus.CLEAR_N;

  // A write into a full FIFO is only legal when a pop frees the slot on the
  // same edge. A pop from an empty FIFO is dropped, so empty+READ+WRITE is a
  // pure write.
  assign re = bus.READ & empty_n;
  assign we = bus.WRITE & (full_n | bus.READ);

  fifo_ram_dp u_ram (
    .clk   (CLOCK),
    .we    (we & ~flush),
    .waddr (wr_ptr),
    .wdata (bus.DATA_IN),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge CLOCK) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (re) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      case ({we, re})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.F_EMPTY_N = empty_n;
  assign bus.F_FULL_N  = full_n;
  // Full wraps to 0 here; F_FULL_N tells it apart from empty.
  assign bus.USE_DW    = count[ADDR_WIDTH-1:0];
  // Gate the head so stale storage never shows while empty.
  assign bus.DATA_OUT  = empty_n ? head : '0;

endmodule : fifo

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - directed self-checking bench for fifo

module tb_fifo;
  import fifo_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  fifo_if bus ();

  fifo dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".empty_n"}, 32'(bus.F_EMPTY_N), 32'd0);
    check({tag, ".full_n"},  32'(bus.F_FULL_N),  32'd1);
    check({tag, ".use_dw"},  32'(bus.USE_DW),    32'd0);
    check({tag, ".dout"},    32'(bus.DATA_OUT),  32'd0);
  endtask

  task automatic push(input logic [7:0] v);
    bus.WRITE   = 1'b1;
    bus.READ    = 1'b0;
    bus.DATA_IN = v;
    tick();
    bus.WRITE   = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] v);
    check(tag, 32'(bus.DATA_OUT), 32'(v));
    bus.READ  = 1'b1;
    bus.WRITE = 1'b0;
    tick();
    bus.READ  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.CLEAR_N = 1'b1;
    bus.DATA_IN = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    check_empty("reset");

    // Underflow: two cycles of READ on an empty FIFO change nothing.
    bus.READ = 1'b1;
    tick();
    tick();
    bus.READ = 1'b0;
    check_empty("underflow");

    // Single word, zero-latency show-ahead.
    push(8'd11);
    check("one.use_dw",  32'(bus.USE_DW),    32'd1);
    check("one.empty_n", 32'(bus.F_EMPTY_N), 32'd1);
    pop_check("one.dout", 8'd11);
    check_empty("one.after");

    // Fill to full with 0..31.
    for (int i = 0; i < 32; i++) push(8'(i));
    check("full.full_n",  32'(bus.F_FULL_N),  32'd0);
    check("full.use_dw",  32'(bus.USE_DW),    32'd0);
    check("full.empty_n", 32'(bus.F_EMPTY_N), 32'd1);
    // Overflow write without READ is dropped.
    push(8'd99);
    check("ovf.full_n", 32'(bus.F_FULL_N), 32'd0);
    check("ovf.use_dw", 32'(bus.USE_DW),   32'd0);
    for (int i = 0; i < 32; i++) pop_check($sformatf("drain%0d", i), 8'(i));
    check_empty("drain.after");

    // Pointer wrap: 40 words, with a concurrent pop once 3 are queued.
    for (int k = 0; k < 40; k++) begin
      bus.WRITE   = 1'b1;
      bus.DATA_IN = 8'(100 + k);
      bus.READ    = (k >= 3);
      if (k >= 3) check($sformatf("wrap%0d", k), 32'(bus.DATA_OUT), 32'(100 + k - 3));
      tick();
      check($sformatf("wrap%0d.use_dw", k), 32'(bus.USE_DW), (k >= 2) ? 32'd3 : 32'(k + 1));
    end
    idle();
    pop_check("wrap.t0", 8'd137);
    pop_check("wrap.t1", 8'd138);
    pop_check("wrap.t2", 8'd139);
    check_empty("wrap.after");

    // Simultaneous READ+WRITE on empty: write only.
    bus.READ    = 1'b1;
    bus.WRITE   = 1'b1;
    bus.DATA_IN = 8'd7;
    tick();
    idle();
    check("sim_e.use_dw", 32'(bus.USE_DW),   32'd1);
    check("sim_e.dout",   32'(bus.DATA_OUT), 32'd7);
    pop_check("sim_e.pop", 8'd7);
    check_empty("sim_e.after");

    // Simultaneous READ+WRITE on full: both happen, stays full.
    for (int i = 0; i < 32; i++) push(8'(50 + i));
    check("sim_f.head0", 32'(bus.DATA_OUT), 32'd50);
    bus.READ    = 1'b1;
    bus.WRITE   = 1'b1;
    bus.DATA_IN = 8'd200;
    tick();
    idle();
    check("sim_f.full_n", 32'(bus.F_FULL_N), 32'd0);
    check("sim_f.head1",  32'(bus.DATA_OUT), 32'd51);
    for (int i = 1; i < 32; i++) pop_check($sformatf("sim_f%0d", i), 8'(50 + i));
    pop_check("sim_f.last", 8'd200);
    check_empty("sim_f.after");

    // CLEAR_N mid-stream with a concurrent WRITE: everything discarded.
    push(8'd1);
    push(8'd2);
    push(8'd3);
    check("clr.pre", 32'(bus.USE_DW), 32'd3);
    bus.CLEAR_N = 1'b0;
    bus.WRITE   = 1'b1;
    bus.DATA_IN = 8'd9;
    tick();
    bus.CLEAR_N = 1'b1;
    idle();
    check_empty("clr");
    push(8'd5);
    check("clr.reuse.use_dw", 32'(bus.USE_DW),   32'd1);
    check("clr.reuse.dout",   32'(bus.DATA_OUT), 32'd5);

    // RESET mid-stream with a concurrent WRITE.
    push(8'd6);
    push(8'd8);
    check("rst.pre", 32'(bus.USE_DW), 32'd3);
    rst         = 1'b1;
    bus.WRITE   = 1'b1;
    bus.DATA_IN = 8'd77;
    tick();
    rst = 1'b0;
    idle();
    check_empty("rst");
    push(8'd44);
    check("rst.reuse.dout", 32'(bus.DATA_OUT), 32'd44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fifo

// File: doc/fifo.md
Name: fifo

Overview:
- Synchronous single-clock byte FIFO, 32 words deep, with first-word-fall-through (show-ahead) output.
- Sits between an 8-bit producer and consumer.
- Provides active-low full/empty flags and a fill-level count.
- Has a global synchronous reset and a separate synchronous clear.

Parameters:
- DATA_WIDTH, 8, word width of DATA_IN/DATA_OUT.
- ADDR_WIDTH, 5, pointer width; DEPTH = 2**ADDR_WIDTH = 32 words.

Ports:
- CLOCK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  reset; synchronous, active-high.
- CLEAR_N  input  1  synchronous active-low flush.
- READ  input  1  pop request; sampled on rising edge.
- WRITE  input  1  push request; sampled on rising edge.
- DATA_IN  input  DATA_WIDTH  word to push.
- DATA_OUT  output  DATA_WIDTH  current head word (show-ahead).
- F_FULL_N  output  1  0 when FIFO holds DEPTH words.
- F_EMPTY_N  output  1  0 when FIFO holds 0 words.
- USE_DW  output  ADDR_WIDTH  word count modulo DEPTH.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Ports are CLOCK and RESET.
- Internal state:
  - write pointer wr_ptr and read pointer rd_ptr, ADDR_WIDTH bits each, wrapping 31->0;
  - count, ADDR_WIDTH+1 bits, range 0..32;
  - 32xDATA_WIDTH storage array.
- Priority per rising edge: RESET > CLEAR_N=0 > read/write.
- RESET=1: wr_ptr=rd_ptr=count=0. Outputs: F_EMPTY_N=0, F_FULL_N=1, USE_DW=0, DATA_OUT=0. Storage contents are not cleared.
- CLEAR_N=0 (RESET=0): same pointer/count/flag effect as RESET. Any READ/WRITE in that cycle is ignored.
- Effective write: we = WRITE & (F_FULL_N | READ).
  - A write when full is accepted only together with an effective read.
  - On we: mem[wr_ptr] <= DATA_IN, wr_ptr++.
- Effective read: re = READ & F_EMPTY_N. A read when empty is ignored, with no pointer or count change.
  - On re: rd_ptr++.
- Count update:
  - we & ~re: +1.
  - re & ~we: -1.
  - both: unchanged.
  - neither: unchanged.
- Empty + READ + WRITE in the same cycle: write only; count becomes 1.
- Full + READ + WRITE: both performed; count stays 32.
- Flags are combinational decodes of the registered count:
  - F_EMPTY_N = (count != 0);
  - F_FULL_N = (count != 32).
- USE_DW = count[ADDR_WIDTH-1:0]. It reads 0 when full; full is distinguished from empty by F_FULL_N.
- DATA_OUT = F_EMPTY_N ? mem[rd_ptr] : 0, combinational from registered state.
  - Zero-latency show-ahead: after the edge that writes into an empty FIFO, DATA_OUT shows that word in the same cycle.
  - The consumer samples DATA_OUT while asserting READ; the edge then advances to the next word.
- Latency:
  - write to USE_DW/flags update: 1 edge;
  - write to DATA_OUT visible (empty FIFO): 1 edge.
- Mid-operation RESET/CLEAR_N discards all stored words immediately on that edge.
- Outputs have no X after the first reset edge.

Decomposition:
- Package fifo_pkg:
  - DATA_WIDTH=8, ADDR_WIDTH=5, DEPTH=32 constants;
  - typedef data_t (logic [DATA_WIDTH-1:0]);
  - typedef ptr_t (logic [ADDR_WIDTH-1:0]);
  - typedef cnt_t (logic [ADDR_WIDTH:0]).
- One sub-module, fifo_ram_dp: DEPTH x DATA_WIDTH register array with a synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata).
- Pointers, count, flags and output gating stay in fifo.

Test Plan:
- Reset, then hold READ=1, WRITE=0 for 2 cycles -> F_EMPTY_N=0, F_FULL_N=1, USE_DW=0, DATA_OUT=0 (underflow ignored).
- Write 11 for one cycle -> next cycle USE_DW=1, F_EMPTY_N=1, DATA_OUT=11 before READ. Then READ for one cycle -> sampled DATA_OUT=11, afterwards USE_DW=0, F_EMPTY_N=0.
- Write 0..31 -> F_FULL_N=0, USE_DW=0, F_EMPTY_N=1. Extra write of 99 with READ=0 is ignored. Read all 32 -> values 0..31 in order, then empty.
- Wrap: write 40 words interleaved with reads keeping count <=5 -> output order matches input order across the 31->0 pointer wrap.
- Simultaneous: at empty, READ+WRITE(7) -> USE_DW=1, DATA_OUT=7. At full, READ+WRITE(200) -> F_FULL_N=0 stays, head advances, 200 emerges last.
- Write 3 words, then CLEAR_N=0 together with WRITE=1 for one cycle -> USE_DW=0, F_EMPTY_N=0. Repeat with RESET=1 mid-stream -> same result.
